// File: rtl/pm_vec_pkg.sv
// pm_vec_pkg: shared definitions for the serial control-vector transmitter.
//   VEC_W           : width of a control vector (16 bits)
//   START_BIT/STOP_BIT : line levels used for the frame delimiters
//   PAR_BITS        : 1 when PM_VEC_TX_PARITY_EN is defined, else 0
//   state_e         : transmitter state encoding (PARITY only with PM_VEC_TX_PARITY_EN)
//   frame_len()     : frame length in clock cycles for a given bit period
package pm_vec_pkg;

    localparam int unsigned VEC_W     = 16;
    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;

`ifdef PM_VEC_TX_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    localparam int unsigned PAR_BITS = 0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    // start + data + optional parity + stop, each baud_div cycles long
    function automatic int unsigned frame_len(input int unsigned baud_div);
        return (VEC_W + 2 + PAR_BITS) * baud_div;
    endfunction

endpackage

// File: rtl/pm_baud_tick.sv
// pm_baud_tick: bit-period counter for pm_vec_tx.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the bit period (state change / idle)
//   tick       : counter is at BAUD_DIV-1 (last cycle of the current bit)
//   tick_nxt   : counter will be at BAUD_DIV-1 next cycle
module pm_baud_tick
    import pm_vec_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick,
    output logic tick_nxt
);

    localparam logic [7:0] LAST = 8'(BAUD_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == LAST);
    // Lets the parent register outputs that must line up with the last cycle
    // of a bit period.
    assign tick_nxt = (cnt_d == LAST);

endmodule

// File: rtl/pm_vec_tx.sv
// pm_vec_tx: serialises a 16-bit control vector as
//   start(0), 16 data bits LSB first, [even parity], stop(1),
// each bit BAUD_DIV clock cycles long.
// Optional feature: define PM_VEC_TX_PARITY_EN to insert the parity bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_data holds a vector to send
//   in_ready   : block accepts a vector this cycle (idle)
//   in_data    : control vector, bit 0 sent first
//   ser_out    : registered serial line, idles at 1
//   busy       : high from the cycle after acceptance through the last stop cycle
//   done       : one-cycle pulse in the last stop cycle
module pm_vec_tx
    import pm_vec_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        ser_out,
    output logic        busy,
    output logic        done
);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   shift_q, shift_d;
    logic [3:0]         idx_q, idx_d;
    logic               ser_q, ser_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef PM_VEC_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    logic clr;
    logic tick;
    logic tick_nxt;

    pm_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .tick     (tick),
        .tick_nxt (tick_nxt)
    );

    assign in_ready = (state_q == IDLE);

    // Next state, shift register and bit index
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef PM_VEC_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = START;
                    shift_d = in_data;
                    idx_d   = '0;
`ifdef PM_VEC_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == 4'(VEC_W - 1)) begin
`ifdef PM_VEC_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = {1'b0, shift_q[VEC_W-1:1]};
                    end
                end
            end
`ifdef PM_VEC_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Holding the counter clear while idle makes every frame start at count 0.
        clr = (state_d != state_q) || (state_q == IDLE);
    end

    // Outputs are computed from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && tick_nxt;
        unique case (state_d)
            START:   ser_d = START_BIT;
            DATA:    ser_d = shift_d[0];
`ifdef PM_VEC_TX_PARITY_EN
            PARITY:  ser_d = par_d;
`endif
            default: ser_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            ser_q   <= STOP_BIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PM_VEC_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PM_VEC_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pm_vec_tx.sv
// Testbench for pm_vec_tx: two instances (BAUD_DIV=4 and BAUD_DIV=1) checked
// every cycle against a frame-position model, plus directed literal checks.
module tb_pm_vec_tx;

`ifdef PM_VEC_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LEN4 = (18 + P) * 4;   // 76 with parity, 72 without
    localparam int LEN1 = (18 + P);       // 19 with parity, 18 without
    // slot 17 of a frame is the parity bit when enabled, else the stop bit
    localparam logic A5C3_SLOT17 = (P == 1) ? 1'b0 : 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv4, ir4, so4, busy4, done4;
    logic [15:0] id4;
    logic        iv1, ir1, so1, busy1, done1;
    logic [15:0] id1;

    pm_vec_tx #(.BAUD_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .in_data(id4), .ser_out(so4), .busy(busy4), .done(done4)
    );

    pm_vec_tx #(.BAUD_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .ser_out(so1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {ser_out, busy, done} at 0-based cycle k of a frame
    function automatic logic [2:0] frame_out(input int k, input int b, input logic [15:0] d);
        int   slot;
        logic s;
        slot = k / b;
        if (slot == 0)                 s = 1'b0;
        else if (slot <= 16)           s = d[slot-1];
        else if (slot == 17 && P == 1) s = ^d;
        else                           s = 1'b1;
        return {s, 1'b1, (k == (18 + P) * b - 1)};
    endfunction

    // Model: whether a frame is in flight, its position and captured data
    logic        m4_act = 1'b0, m1_act = 1'b0;
    int          m4_k = 0, m1_k = 0;
    logic [15:0] m4_d = '0, m1_d = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4_act <= 1'b0; m4_k <= 0;
        end else if (m4_act) begin
            if (m4_k == LEN4 - 1) m4_act <= 1'b0;
            else                  m4_k   <= m4_k + 1;
        end else if (iv4) begin
            m4_act <= 1'b1; m4_k <= 0; m4_d <= id4;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_act <= 1'b0; m1_k <= 0;
        end else if (m1_act) begin
            if (m1_k == LEN1 - 1) m1_act <= 1'b0;
            else                  m1_k   <= m1_k + 1;
        end else if (iv1) begin
            m1_act <= 1'b1; m1_k <= 0; m1_d <= id1;
        end
    end

    logic [2:0] e4, e1;
    always @(negedge clk) begin
        e4 = m4_act ? frame_out(m4_k, 4, m4_d) : 3'b100;
        e1 = m1_act ? frame_out(m1_k, 1, m1_d) : 3'b100;
        chk("dut4.ser_out",  so4,   e4[2]);
        chk("dut4.busy",     busy4, e4[1]);
        chk("dut4.done",     done4, e4[0]);
        chk("dut4.in_ready", ir4,   !m4_act);
        chk("dut1.ser_out",  so1,   e1[2]);
        chk("dut1.busy",     busy1, e1[1]);
        chk("dut1.done",     done1, e1[0]);
        chk("dut1.in_ready", ir1,   !m1_act);
    end

    logic cap4 [0:200];
    logic cap1 [0:200];
    int   done_at4, busy_cnt4, done_at1, busy_cnt1;

    task automatic wait_idle4();
        int n = 0;
        while (ir4 !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("dut4 idle wait", ir4, 1'b1);
    endtask

    // Called #1 after the accepting edge; records one frame from cycle 1.
    task automatic capture4(input int chg_at, input logic [15:0] alt);
        done_at4  = 0;
        busy_cnt4 = 0;
        for (int k = 1; k <= 200 && done_at4 == 0; k++) begin
            @(negedge clk);
            cap4[k] = so4;
            if (busy4 === 1'b1) busy_cnt4++;
            if (done4 === 1'b1) done_at4 = k;
            if (k == chg_at) id4 = alt;
        end
        chk("dut4 done cycle", done_at4, LEN4);
        chk("dut4 busy cycles", busy_cnt4, LEN4);
    endtask

    task automatic run4(input logic [15:0] d, input int chg_at, input logic [15:0] alt);
        wait_idle4();
        iv4 = 1'b1; id4 = d;
        @(posedge clk); #1; iv4 = 1'b0;
        capture4(chg_at, alt);
    endtask

    // Data bit i occupies frame cycles 4*(i+1)+1 .. 4*(i+1)+4; sample mid-bit
    function automatic logic [15:0] word4();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = cap4[4 * (i + 1) + 2];
        return w;
    endfunction

    initial begin
        rst_n = 1'b0;
        iv4 = 1'b0; id4 = '0;
        iv1 = 1'b0; id1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ser4", so4, 1'b1);
        chk("reset ready4", ir4, 1'b1);
        chk("reset busy4", busy4, 1'b0);
        chk("reset done4", done4, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single set bit, then parity/stop
        run4(16'h0001, 0, '0);
        chk("0001 start", cap4[2], 1'b0);
        chk("0001 word", word4(), 16'h0001);
        chk("0001 slot17", cap4[4 * 17 + 2], 1'b1);
        chk("0001 last stop", cap4[LEN4], 1'b1);

        run4(16'hA5C3, 0, '0);
        chk("A5C3 word", word4(), 16'hA5C3);
        chk("A5C3 slot17", cap4[4 * 17 + 2], A5C3_SLOT17);

        // input change mid-frame must not reach the line
        run4(16'hFFFF, 20, 16'h0000);
        chk("FFFF held word", word4(), 16'hFFFF);

        // back-to-back with in_valid held high
        wait_idle4();
        iv4 = 1'b1; id4 = 16'h1234;
        @(posedge clk); #1;
        id4 = 16'h5678;
        done_at4 = 0;
        for (int k = 1; k <= 200 && done_at4 == 0; k++) begin
            @(negedge clk);
            if (done4 === 1'b1) done_at4 = k;
        end
        chk("b2b first done", done_at4, LEN4);
        @(negedge clk);
        chk("b2b gap ready", ir4, 1'b1);
        chk("b2b gap ser", so4, 1'b1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(negedge clk);
        chk("b2b second busy", busy4, 1'b1);
        chk("b2b second start", so4, 1'b0);
        wait_idle4();

        // reset in frame cycle 30 (a 0 data bit of AAAA)
        iv4 = 1'b1; id4 = 16'hAAAA;
        @(posedge clk); #1; iv4 = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("pre-reset ser", so4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort ser", so4, 1'b1);
        chk("abort busy", busy4, 1'b0);
        chk("abort done", done4, 1'b0);
        chk("abort ready", ir4, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        iv4 = 1'b1; id4 = 16'h00FF;
        @(posedge clk); #1; iv4 = 1'b0;
        capture4(0, '0);
        chk("00FF after reset", word4(), 16'h00FF);

        // BAUD_DIV=1 instance
        iv1 = 1'b1; id1 = 16'hFFFF;
        @(posedge clk); #1; iv1 = 1'b0;
        done_at1 = 0; busy_cnt1 = 0;
        for (int k = 1; k <= 60 && done_at1 == 0; k++) begin
            @(negedge clk);
            cap1[k] = so1;
            if (busy1 === 1'b1) busy_cnt1++;
            if (done1 === 1'b1) done_at1 = k;
        end
        chk("div1 done cycle", done_at1, LEN1);
        chk("div1 busy cycles", busy_cnt1, LEN1);
        chk("div1 start", cap1[1], 1'b0);
        begin
            logic [15:0] w1;
            for (int i = 0; i < 16; i++) w1[i] = cap1[2 + i];
            chk("div1 FFFF word", w1, 16'hFFFF);
        end
        chk("div1 stop", cap1[LEN1], 1'b1);
        @(posedge clk); #1;
        iv1 = 1'b1; id1 = 16'h8001;
        @(posedge clk); #1; iv1 = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("div1 idle after 8001", ir1, 1'b1);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
